// File: rtl/pool_pkg.sv
// Shared types, constants and helpers for the max-pooling datapath.
// Lane slicing and the signed max live here so every lane uses the same compare.
package pool_pkg;

    localparam int DATA_W    = 16;
    localparam int LANES_MAX = 16;
    localparam int WIN_W     = 4;
    localparam int K_MIN     = 1;
    localparam int K_MAX     = 3;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef logic [LANES_MAX*DATA_W-1:0] lanes_t;

    function automatic elem_t lane_slice(
        input lanes_t v,
        input int     c
    );
        return v[c*DATA_W +: DATA_W];
    endfunction

    // Ties keep the first operand (the running value).
    function automatic elem_t smax(
        input elem_t a,
        input elem_t b
    );
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/pool_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
// A push into a full FIFO is only taken when a pop frees the slot that cycle.
module pool_result_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          wr_ok
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_ok = pop && !empty;
    assign wr_ok = push && (!full || rd_ok);

    // Head reads as zero while empty so stale slots never leak out.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pooling_max_unit.sv
// Per-column signed max over KxK pooling windows, buffered toward write-back.
// Bypass mode forwards the array outputs straight into the same FIFO.
module pooling_max_unit
    import pool_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pooling_en,
    input  logic [2:0]             POOLING_KERNEL_DIM,
    input  logic [2:0]             POOLING_WINDOW_PER_PERIOD,
    input  logic [COLS*DATA_W-1:0] data_i,
    input  logic [COLS-1:0]        input_flag_PL_O,
    input  logic [COLS-1:0]        pooling_signal_o,
    input  logic [1:0]             cnt_PL_kernel_x,
    input  logic [1:0]             cnt_PL_kernel_y,
    input  logic [3:0]             cnt_PL_window,
    input  logic                   clr_err,
    output logic [COLS*DATA_W-1:0] pool_data_o,
    output logic                   pool_valid_o,
    output logic [3:0]             pool_window_o,
    input  logic                   pool_ready_i,
    output logic                   out_flag_pooling,
    output logic                   ovf_err
);

    localparam int VEC_W = COLS * DATA_W;
    localparam int ENT_W = VEC_W + WIN_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             k_legal;
    logic [1:0]       k_last;
    logic             first;
    logic             last;
    logic [COLS-1:0]  sample;
    lanes_t           data_ext;
    logic [VEC_W-1:0] res_vec;
    logic             unused_cfg;

    assign unused_cfg = ^POOLING_WINDOW_PER_PERIOD;

    assign k_legal = (POOLING_KERNEL_DIM >= 3'(K_MIN))
                  && (POOLING_KERNEL_DIM <= 3'(K_MAX));
    assign k_last  = POOLING_KERNEL_DIM[1:0] - 2'd1;
    assign first   = (cnt_PL_kernel_x == 2'd0)
                  && (cnt_PL_kernel_y == 2'd0);
    assign last    = (cnt_PL_kernel_x == k_last)
                  && (cnt_PL_kernel_y == k_last);

    // Stray strobes (flag without pooling-active) and illegal K never accumulate.
    assign sample = input_flag_PL_O & pooling_signal_o
                  & {COLS{pooling_en && k_legal}};

    always_comb begin
        data_ext = '0;
        data_ext[VEC_W-1:0] = data_i;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        elem_t acc;
        elem_t d;
        elem_t cand;

        assign d    = lane_slice(data_ext, c);
        assign cand = first ? d : smax(acc, d);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                acc <= '0;
            else if (!pooling_en)
                acc <= '0;
            else if (sample[c])
                acc <= cand;
        end

        assign res_vec[c*DATA_W +: DATA_W] = cand;
    end

    logic             push_pool;
    logic             push_byp;
    logic             push;
    logic [ENT_W-1:0] din;
    logic [ENT_W-1:0] head;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             wr_ok;
    logic             rd_ok;
    logic [CNT_W-1:0] post_occ;
    logic             flag_d;
    logic             ovf_set;

    assign push_pool = sample[0] && last;
    assign push_byp  = !pooling_en && input_flag_PL_O[0];
    assign push      = push_pool || push_byp;
    assign din       = pooling_en ? {res_vec, cnt_PL_window}
                                  : {data_i, 4'd0};

    assign rd_ok = pool_valid_o && pool_ready_i;

    pool_result_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pool_ready_i),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .count (count),
        .wr_ok (wr_ok)
    );

    assign pool_valid_o  = !empty;
    assign pool_data_o   = head[ENT_W-1:WIN_W];
    assign pool_window_o = head[WIN_W-1:0];

    // Re-arm only while the FIFO still has room after this write lands.
    assign post_occ = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    assign flag_d   = push_pool && wr_ok
                   && (post_occ < CNT_W'(FIFO_DEPTH));
    assign ovf_set  = push && full && !rd_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flag_pooling <= 1'b0;
            ovf_err          <= 1'b0;
        end else begin
            out_flag_pooling <= flag_d;
            if (ovf_set)
                ovf_err <= 1'b1;
            else if (clr_err)
                ovf_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pooling_max_unit.sv
// Directed, table-driven bench for pooling_max_unit.
// Rows drive one cycle each; multi-cycle corners are hand-written sequences.
module tb_pooling_max_unit;

    logic        clk;
    logic        rst_n;
    logic        pooling_en;
    logic [2:0]  POOLING_KERNEL_DIM;
    logic [2:0]  POOLING_WINDOW_PER_PERIOD;
    logic [63:0] data_i;
    logic [3:0]  input_flag_PL_O;
    logic [3:0]  pooling_signal_o;
    logic [1:0]  cnt_PL_kernel_x;
    logic [1:0]  cnt_PL_kernel_y;
    logic [3:0]  cnt_PL_window;
    logic        clr_err;
    logic [63:0] pool_data_o;
    logic        pool_valid_o;
    logic [3:0]  pool_window_o;
    logic        pool_ready_i;
    logic        out_flag_pooling;
    logic        ovf_err;

    pooling_max_unit dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .pooling_en                (pooling_en),
        .POOLING_KERNEL_DIM        (POOLING_KERNEL_DIM),
        .POOLING_WINDOW_PER_PERIOD (POOLING_WINDOW_PER_PERIOD),
        .data_i                    (data_i),
        .input_flag_PL_O           (input_flag_PL_O),
        .pooling_signal_o          (pooling_signal_o),
        .cnt_PL_kernel_x           (cnt_PL_kernel_x),
        .cnt_PL_kernel_y           (cnt_PL_kernel_y),
        .cnt_PL_window             (cnt_PL_window),
        .clr_err                   (clr_err),
        .pool_data_o               (pool_data_o),
        .pool_valid_o              (pool_valid_o),
        .pool_window_o             (pool_window_o),
        .pool_ready_i              (pool_ready_i),
        .out_flag_pooling          (out_flag_pooling),
        .ovf_err                   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  k;
        logic        en;
        logic        fl;
        logic [1:0]  kx;
        logic [1:0]  ky;
        logic [3:0]  win;
        logic [63:0] d;
        logic        rdy;
        logic        ev;
        logic        ef;
        logic [63:0] eh;
        logic [3:0]  ew;
    } vec_t;

    vec_t tbl [32];
    int   ntbl = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [63:0] v4(input int a, input int b,
                                       input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic add(input logic [2:0] k, input logic en, input logic fl,
                       input logic [1:0] kx, input logic [1:0] ky,
                       input logic [3:0] win, input logic [63:0] d,
                       input logic rdy, input logic ev, input logic ef,
                       input logic [63:0] eh, input logic [3:0] ew);
        tbl[ntbl].k   = k;
        tbl[ntbl].en  = en;
        tbl[ntbl].fl  = fl;
        tbl[ntbl].kx  = kx;
        tbl[ntbl].ky  = ky;
        tbl[ntbl].win = win;
        tbl[ntbl].d   = d;
        tbl[ntbl].rdy = rdy;
        tbl[ntbl].ev  = ev;
        tbl[ntbl].ef  = ef;
        tbl[ntbl].eh  = eh;
        tbl[ntbl].ew  = ew;
        ntbl++;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        input_flag_PL_O  = 4'b0;
        pooling_signal_o = 4'b0;
        cnt_PL_kernel_x  = 2'd0;
        cnt_PL_kernel_y  = 2'd0;
        cnt_PL_window    = 4'd0;
        data_i           = 64'd0;
        clr_err          = 1'b0;
        pool_ready_i     = 1'b0;
    endtask

    task automatic drive(input logic [2:0] k, input logic [1:0] kx,
                         input logic [1:0] ky, input logic [3:0] win,
                         input logic [63:0] d);
        POOLING_KERNEL_DIM = k;
        input_flag_PL_O    = 4'hF;
        pooling_signal_o   = 4'hF;
        cnt_PL_kernel_x    = kx;
        cnt_PL_kernel_y    = ky;
        cnt_PL_window      = win;
        data_i             = d;
    endtask

    task automatic run_row(input int i);
        POOLING_KERNEL_DIM = tbl[i].k;
        pooling_en         = tbl[i].en;
        input_flag_PL_O    = {4{tbl[i].fl}};
        pooling_signal_o   = {4{tbl[i].fl}};
        cnt_PL_kernel_x    = tbl[i].kx;
        cnt_PL_kernel_y    = tbl[i].ky;
        cnt_PL_window      = tbl[i].win;
        data_i             = tbl[i].d;
        pool_ready_i       = tbl[i].rdy;
        tick();
        chk($sformatf("row%0d valid", i), 64'(pool_valid_o), 64'(tbl[i].ev));
        chk($sformatf("row%0d flag", i), 64'(out_flag_pooling), 64'(tbl[i].ef));
        chk($sformatf("row%0d ovf", i), 64'(ovf_err), 64'd0);
        if (tbl[i].ev) begin
            chk($sformatf("row%0d head", i), pool_data_o, tbl[i].eh);
            chk($sformatf("row%0d win", i), 64'(pool_window_o), 64'(tbl[i].ew));
        end
    endtask

    task automatic pop_expect(input string name, input logic [63:0] eh,
                              input logic [3:0] ew);
        chk({name, " valid"}, 64'(pool_valid_o), 64'd1);
        chk({name, " head"}, pool_data_o, eh);
        chk({name, " win"}, 64'(pool_window_o), 64'(ew));
        pool_ready_i = 1'b1;
        tick();
        pool_ready_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, " data"}, pool_data_o, 64'd0);
        chk({name, " valid"}, 64'(pool_valid_o), 64'd0);
        chk({name, " win"}, 64'(pool_window_o), 64'd0);
        chk({name, " flag"}, 64'(out_flag_pooling), 64'd0);
        chk({name, " ovf"}, 64'(ovf_err), 64'd0);
    endtask

    initial begin
        // K=2 single window 3,-7,9,2 -> 9
        add(3'd2, 1'b1, 1'b1, 2'd0, 2'd0, 4'd0, v4(3, 0, 0, 0),
            1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
        add(3'd2, 1'b1, 1'b1, 2'd1, 2'd0, 4'd0, v4(-7, 0, 0, 0),
            1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
        add(3'd2, 1'b1, 1'b1, 2'd0, 2'd1, 4'd0, v4(9, 0, 0, 0),
            1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
        add(3'd2, 1'b1, 1'b1, 2'd1, 2'd1, 4'd5, v4(2, 0, 0, 0),
            1'b0, 1'b1, 1'b1, v4(9, 0, 0, 0), 4'd5);
        add(3'd2, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 64'd0,
            1'b1, 1'b0, 1'b0, 64'd0, 4'd0);
        // K=2 negatives on lane 0, distinct lanes 1..3
        add(3'd2, 1'b1, 1'b1, 2'd0, 2'd0, 4'd0, v4(-5, 1, -1, 100),
            1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
        add(3'd2, 1'b1, 1'b1, 2'd1, 2'd0, 4'd0, v4(-2, 4, -1, -100),
            1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
        add(3'd2, 1'b1, 1'b1, 2'd0, 2'd1, 4'd0, v4(-9, 2, -1, 50),
            1'b0, 1'b0, 1'b0, 64'd0, 4'd0);
        add(3'd2, 1'b1, 1'b1, 2'd1, 2'd1, 4'd2, v4(-2, 3, -1, 7),
            1'b0, 1'b1, 1'b1, v4(-2, 4, -1, 100), 4'd2);
        add(3'd2, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 64'd0,
            1'b1, 1'b0, 1'b0, 64'd0, 4'd0);
        // K=1 fill: fourth write leaves FIFO full, no re-arm
        add(3'd1, 1'b1, 1'b1, 2'd0, 2'd0, 4'd0, v4(10, 0, 0, 0),
            1'b0, 1'b1, 1'b1, v4(10, 0, 0, 0), 4'd0);
        add(3'd1, 1'b1, 1'b1, 2'd0, 2'd0, 4'd1, v4(20, 0, 0, 0),
            1'b0, 1'b1, 1'b1, v4(10, 0, 0, 0), 4'd0);
        add(3'd1, 1'b1, 1'b1, 2'd0, 2'd0, 4'd2, v4(30, 0, 0, 0),
            1'b0, 1'b1, 1'b1, v4(10, 0, 0, 0), 4'd0);
        add(3'd1, 1'b1, 1'b1, 2'd0, 2'd0, 4'd3, v4(40, 0, 0, 0),
            1'b0, 1'b1, 1'b0, v4(10, 0, 0, 0), 4'd0);
        // bypass A, B, C with nonzero counters: window must read 0
        add(3'd2, 1'b0, 1'b1, 2'd1, 2'd1, 4'd7, v4(1, 2, 3, 4),
            1'b0, 1'b1, 1'b0, v4(1, 2, 3, 4), 4'd0);
        add(3'd2, 1'b0, 1'b1, 2'd0, 2'd0, 4'd7, v4(-1, -2, -3, -4),
            1'b0, 1'b1, 1'b0, v4(1, 2, 3, 4), 4'd0);
        add(3'd2, 1'b0, 1'b1, 2'd1, 2'd0, 4'd7, v4(32767, -32768, 0, 5),
            1'b0, 1'b1, 1'b0, v4(1, 2, 3, 4), 4'd0);

        rst_n = 1'b0;
        pooling_en = 1'b1;
        POOLING_KERNEL_DIM = 3'd2;
        POOLING_WINDOW_PER_PERIOD = 3'd2;
        idle();
        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++)
            run_row(i);

        // full, no pop: dropped, sticky error, head unchanged
        drive(3'd1, 2'd0, 2'd0, 4'd4, v4(50, 0, 0, 0));
        tick();
        chk("drop ovf", 64'(ovf_err), 64'd1);
        chk("drop flag", 64'(out_flag_pooling), 64'd0);
        chk("drop head", pool_data_o, v4(10, 0, 0, 0));
        idle();
        clr_err = 1'b1;
        tick();
        chk("clr ovf", 64'(ovf_err), 64'd0);
        drive(3'd1, 2'd0, 2'd0, 4'd4, v4(55, 0, 0, 0));
        clr_err = 1'b1;
        tick();
        chk("set beats clr", 64'(ovf_err), 64'd1);
        idle();
        clr_err = 1'b1;
        tick();
        chk("clr again", 64'(ovf_err), 64'd0);
        // full with same-cycle pop: accepted, still full
        drive(3'd1, 2'd0, 2'd0, 4'd5, v4(60, 0, 0, 0));
        pool_ready_i = 1'b1;
        tick();
        idle();
        chk("push+pop ovf", 64'(ovf_err), 64'd0);
        chk("push+pop flag", 64'(out_flag_pooling), 64'd0);
        pop_expect("drain1", v4(20, 0, 0, 0), 4'd1);
        pop_expect("drain2", v4(30, 0, 0, 0), 4'd2);
        pop_expect("drain3", v4(40, 0, 0, 0), 4'd3);
        pop_expect("drain4", v4(60, 0, 0, 0), 4'd5);
        chk("drained", 64'(pool_valid_o), 64'd0);

        for (int i = 14; i < ntbl; i++)
            run_row(i);
        idle();
        pooling_en = 1'b1;
        pop_expect("bypA", v4(1, 2, 3, 4), 4'd0);
        pop_expect("bypB", v4(-1, -2, -3, -4), 4'd0);
        pop_expect("bypC", v4(32767, -32768, 0, 5), 4'd0);
        chk("byp empty", 64'(pool_valid_o), 64'd0);

        // buffered entry plus half window, then reset
        drive(3'd1, 2'd0, 2'd0, 4'd9, v4(77, 0, 0, 0));
        tick();
        chk("pre-rst valid", 64'(pool_valid_o), 64'd1);
        drive(3'd2, 2'd0, 2'd0, 4'd1, v4(50, 0, 0, 0));
        tick();
        drive(3'd2, 2'd1, 2'd0, 4'd1, v4(60, 0, 0, 0));
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        drive(3'd2, 2'd0, 2'd0, 4'd3, v4(1, 1, 1, 1));
        tick();
        drive(3'd2, 2'd1, 2'd0, 4'd3, v4(1, 1, 1, 1));
        tick();
        drive(3'd2, 2'd0, 2'd1, 4'd3, v4(1, 1, 1, 1));
        tick();
        drive(3'd2, 2'd1, 2'd1, 4'd3, v4(8, 1, 1, 1));
        tick();
        idle();
        chk("post-rst flag", 64'(out_flag_pooling), 64'd1);
        pop_expect("post-rst", v4(8, 1, 1, 1), 4'd3);
        chk("post-rst empty", 64'(pool_valid_o), 64'd0);

        // illegal K must not push
        drive(3'd0, 2'd3, 2'd3, 4'd1, v4(5, 5, 5, 5));
        tick();
        chk("k0 valid", 64'(pool_valid_o), 64'd0);
        drive(3'd4, 2'd3, 2'd3, 4'd1, v4(5, 5, 5, 5));
        tick();
        chk("k4 valid", 64'(pool_valid_o), 64'd0);
        chk("k4 flag", 64'(out_flag_pooling), 64'd0);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
